// File: rtl/serializer_pkg.sv
// Shared constants and helpers for the parallel-in/serial-out serializer.
package serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-counter width for a word of w bits; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-word holding buffer in front of the shift register.
module piso_hold_reg #(
  parameter int unsigned WIDTH = serializer_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full,
  output logic             in_ready
);

  // Load wins over drain; the two never coincide because in_ready is low while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (load) begin
      hold_data <= load_data;
      hold_full <= 1'b1;
    end else if (drain) begin
      hold_full <= 1'b0;
    end
  end

  assign in_ready = !hold_full;

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out bit serializer feeding a serial sequence detector.
module piso_bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    bit_cnt, bit_cnt_d;
  logic             word_done_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             last_bit;
  logic             hold_load;
  logic             hold_drain;
  logic [WIDTH-1:0] shreg_shifted;

  assign accept   = in_valid && in_ready;
  assign last_bit = (state == SHIFT) && bit_en && (bit_cnt == LAST);
  // A word accepted on the final bit of the current word (buffer empty) goes straight
  // into the shift register, so a full buffer is never left behind in IDLE.
  assign hold_load  = accept && (state == SHIFT) && !last_bit;
  assign hold_drain = last_bit && hold_full;

  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  piso_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hold_load),
    .load_data(in_data),
    .drain    (hold_drain),
    .hold_data(hold_data),
    .hold_full(hold_full),
    .in_ready (in_ready)
  );

  // Next-state logic for the FSM, shift register, bit counter and done pulse.
  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    bit_cnt_d   = bit_cnt;
    word_done_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_d   = in_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (bit_cnt == LAST) begin
            word_done_d = 1'b1;
            bit_cnt_d   = '0;
            if (hold_full) begin
              shreg_d = hold_data;
            end else if (accept) begin
              shreg_d = in_data;
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d   = shreg_shifted;
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // State registers; reset discards both the partial and the buffered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      bit_cnt   <= bit_cnt_d;
      word_done <= word_done_d;
    end
  end

  // Outputs decode registered state only, so dout is glitch-free for the detector.
  always_comb begin
    dout_valid = (state == SHIFT);
    dout       = dout_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    busy       = (state == SHIFT) || hold_full;
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first serializers against a word-queue model.
module tb_piso_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         bit_en;
  logic         ready0, dout0, dv0, busy0, wd0;
  logic         ready1, dout1, dv1, busy1, wd1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ready0),
    .bit_en(bit_en), .dout(dout0), .dout_valid(dv0), .busy(busy0), .word_done(wd0)
  );

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ready1),
    .bit_en(bit_en), .dout(dout1), .dout_valid(dv1), .busy(busy1), .word_done(wd1)
  );

  // Model: the word being sent plus its bit index, and at most one waiting word.
  typedef struct {
    bit         active;
    bit [W-1:0] cur;
    int         idx;
    bit         pend_v;
    bit [W-1:0] pend;
    bit         done;
  } mdl_t;

  mdl_t m[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].active = 0; m[k].cur = '0; m[k].idx = 0;
      m[k].pend_v = 0; m[k].pend = '0; m[k].done = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      bit acc;
      acc = in_valid && !m[k].pend_v;
      m[k].done = 0;
      if (m[k].active && bit_en) begin
        if (m[k].idx == W - 1) begin
          m[k].done   = 1;
          m[k].active = 0;
        end else begin
          m[k].idx++;
        end
      end
      if (acc) begin
        m[k].pend_v = 1;
        m[k].pend   = in_data;
      end
      if (!m[k].active && m[k].pend_v) begin
        m[k].active = 1;
        m[k].cur    = m[k].pend;
        m[k].idx    = 0;
        m[k].pend_v = 0;
      end
    end
  endtask

  function automatic logic exp_dout(input int k);
    int pos;
    if (!m[k].active) return 1'b0;
    pos = (k == 0) ? (W - 1 - m[k].idx) : m[k].idx;
    return m[k].cur[pos];
  endfunction

  task automatic check_all();
    check_val("msb dout",  dout0,  exp_dout(0));
    check_val("msb valid", dv0,    m[0].active);
    check_val("msb busy",  busy0,  m[0].active || m[0].pend_v);
    check_val("msb ready", ready0, !m[0].pend_v);
    check_val("msb done",  wd0,    m[0].done);
    check_val("lsb dout",  dout1,  exp_dout(1));
    check_val("lsb valid", dv1,    m[1].active);
    check_val("lsb busy",  busy1,  m[1].active || m[1].pend_v);
    check_val("lsb ready", ready1, !m[1].pend_v);
    check_val("lsb done",  wd1,    m[1].done);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_clock();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    check_val("rst dout",  dout0,  1'b0);
    check_val("rst valid", dv0,    1'b0);
    check_val("rst ready", ready0, 1'b1);
    check_val("rst busy",  busy0,  1'b0);
    check_val("rst done",  wd0,    1'b0);
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic collect(input int n, output logic [31:0] s0, output logic [31:0] s1);
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < n; i++) begin
      s0 = {s0[30:0], dout0};
      s1 = {s1[30:0], dout1};
      tick();
    end
  endtask

  logic [31:0] s0, s1;
  logic [15:0] b0, b1;

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    bit_en   = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();
    tick();

    // Single word A5, one bit per clock.
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    collect(8, s0, s1);
    check_val("a5 msb seq", s0[7:0], 8'hA5);
    check_val("a5 lsb seq", s1[7:0], 8'hA5);
    check_val("a5 done c9", wd0, 1'b1);
    check_val("a5 idle c9", dv0, 1'b0);
    tick();

    // Back-to-back A5 then 0F with in_valid held.
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    b0 = {15'd0, dout0}; b1 = {15'd0, dout1};
    in_data = 8'h0F;
    tick();
    check_val("b2b ready c2", ready0, 1'b0);
    in_valid = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      b0 = {b0[14:0], dout0};
      b1 = {b1[14:0], dout1};
      check_val("b2b contig", dv0, 1'b1);
      if (c == 8) check_val("b2b ready c8", ready0, 1'b0);
      if (c == 9) check_val("b2b done c9", wd0, 1'b1);
      if (c == 9) check_val("b2b ready c9", ready0, 1'b1);
      tick();
    end
    check_val("b2b msb seq", b0, 16'hA50F);
    check_val("b2b lsb seq", b1, 16'hA5F0);
    check_val("b2b done c17", wd0, 1'b1);
    check_val("b2b idle c17", dv0, 1'b0);
    tick();

    // Strobed advance every 4th cycle, word C3.
    bit_en = 1'b0;
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    s0 = '0; s1 = '0;
    for (int c = 1; c <= 32; c++) begin
      s0 = {s0[30:0], dout0};
      s1 = {s1[30:0], dout1};
      bit_en = (c % 4 == 0);
      tick();
    end
    bit_en = 1'b1;
    check_val("strobe msb seq", s0, 32'hFF0000FF);
    check_val("strobe lsb seq", s1, 32'hFF0000FF);
    check_val("strobe done", wd0, 1'b1);
    tick();

    // Reset mid-word with a second word buffered.
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    do_reset();
    tick();
    in_valid = 1'b1; in_data = 8'h80;
    tick();
    in_valid = 1'b0;
    collect(8, s0, s1);
    check_val("post-rst msb seq", s0[7:0], 8'h80);
    check_val("post-rst lsb seq", s1[7:0], 8'h01);
    tick();
    check_val("buffer dropped", dv0, 1'b0);

    // LSB-first word 01.
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_valid = 1'b0;
    collect(8, s0, s1);
    check_val("w01 lsb seq", s1[7:0], 8'h80);
    check_val("w01 msb seq", s0[7:0], 8'h01);
    tick();

    // Randomized traffic, strobes and occasional resets, checked every cycle.
    for (int i = 0; i < 4000; i++) begin
      bit acc;
      bit_en = ($urandom_range(0, 3) != 0);
      acc = in_valid && !m[0].pend_v;
      tick();
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = W'($urandom);
      end
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piso_bit_serializer.md
# piso_bit_serializer

Parallel-in/serial-out stage that sits directly upstream of the Moore sequence detector and drives its serial `din`. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts words out one bit per advance strobe. Back-to-back words stream with no idle bit between them. The detector's input sees 0 when no word is being shifted.

## Interface
- `WIDTH`, 8: bits per word; must be ≥ 2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 first, 0 = bit 0 first.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_data`  in  WIDTH  parallel word.
- `in_valid`  in  1  `in_data` valid. Must stay high with `in_data` stable until accepted.
- `in_ready`  out  1  word can be accepted this cycle.
- `bit_en`  in  1  bit-advance strobe. Tie to 1 for one bit per clock.
- `dout`  out  1  serial bit, registered. Connects to the detector's `din`.
- `dout_valid`  out  1  `dout` carries a word bit.
- `busy`  out  1  shift register or holding buffer occupied.
- `word_done`  out  1  one-cycle pulse after the last bit of a word has been consumed.

## Operation
- Storage:
  - holding buffer: `hold_data`, `hold_full`;
  - shift register: `shreg`, `bit_cnt` [$clog2(WIDTH)-1:0];
  - 2-state FSM: IDLE, SHIFT.
- `in_ready = !hold_full`, combinational from the register. Accept = `in_valid && in_ready` at a rising edge.
- IDLE:
  - `dout=0`, `dout_valid=0`.
  - An accepted word bypasses the buffer into `shreg`: `bit_cnt=0`, go to SHIFT.
  - A full buffer in IDLE cannot occur. The bypass path rules it out.
- SHIFT:
  - `dout` = current bit of `shreg`, `dout_valid=1`.
  - An accepted word goes to the holding buffer.
  - On `bit_en` with `bit_cnt < WIDTH-1`: shift toward the output end, `bit_cnt++`.
  - On `bit_en` with `bit_cnt == WIDTH-1`: the word is finished and `word_done` is set for the next cycle. Then:
    - if `hold_full`: move the buffer into `shreg`, `bit_cnt=0`, clear `hold_full`, stay in SHIFT (gapless);
    - else: go to IDLE, `dout=0`.
  - With `bit_en=0`: shift state is frozen and `dout` is held. The handshake still operates.
- Simultaneous accept and buffer drain in one cycle cannot occur, because `in_ready` is low while the buffer is full.
- `busy = (state==SHIFT) || hold_full`.
- Reset, including mid-word:
  - state IDLE; `hold_full=0`, `shreg=0`, `bit_cnt=0`;
  - `dout=0`, `dout_valid=0`, `word_done=0`;
  - `in_ready=1`, `busy=0`;
  - the partial word and the buffered word are discarded.

## Timing
- Handshake in cycle t while IDLE: first bit on `dout` in cycle t+1. This holds whether `bit_en` is high or low.
- Handshake in cycle t while in SHIFT: the word occupies the buffer and `in_ready` is low from t+1. The word starts the cycle after the current word's last bit is consumed.
- With `bit_en=1` continuously:
  - each bit is presented for exactly 1 cycle;
  - N back-to-back words produce N·WIDTH contiguous valid bits.
- With strobed `bit_en`: each bit is held from one strobe until the cycle after the next strobe.
- `word_done` is high in the cycle immediately after the final bit's `bit_en` cycle. It is the same cycle as the next word's first bit, or the first IDLE cycle.

## Structure
- Shared package `serializer_pkg`:
  - FSM state constants (IDLE=1'b0, SHIFT=1'b1);
  - the counter-width function;
  - the default WIDTH constant.
- One sub-module, `piso_hold_reg`: the one-word holding buffer (data, full flag, load/drain, `in_ready` generation).
- The shift register, counter and FSM stay in the top module.

## Test plan
- Reset: assert `rst_n=0` mid-idle → `dout=0`, `dout_valid=0`, `in_ready=1`, `busy=0`, `word_done=0`, with no clock edge needed.
- Single word 8'hA5, MSB_FIRST=1, `bit_en=1`, handshake in cycle 0:
  - `dout` = 1,0,1,0,0,1,0,1 in cycles 1–8;
  - `word_done`=1 and `dout_valid`=0 in cycle 9.
- Back-to-back 8'hA5 then 8'h0F with `in_valid` held high:
  - `in_ready` low from cycle 2 to cycle 8;
  - 16 contiguous valid bits `1010010100001111`;
  - `word_done` pulses in cycles 9 and 17;
  - downstream detector pulses on each "101".
- `bit_en` high every 4th cycle, word 8'hC3 → each bit held 4 cycles and the sequence is 1,1,0,0,0,0,1,1.
- Reset mid-word:
  - `rst_n` low after 3 bits of 8'hFF → outputs cleared asynchronously, buffered word dropped;
  - after release, new word 8'h80 → `dout` = 1 then seven 0s.
- MSB_FIRST=0, word 8'h01 → `dout` = 1 then seven 0s. Word 8'h80 → seven 0s then 1.
